mem_access_ctrl: RTL and testbench

- MEM-stage memory access controller, directly downstream of the store-data packager.
- Consumes the packaged store data and byte mask (or a load request) and drives a valid/ready request channel to the data memory.
- For loads, waits for the memory response, then right-aligns, truncates and sign/zero-extends the read data for writeback.
- Stalls the pipeline until the access completes.

---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/load_extract.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage memory access controller.
package mem_access_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;

    // Access sizes in bytes as presented on op_width.
    localparam logic [3:0] WIDTH_B = 4'd1;
    localparam logic [3:0] WIDTH_H = 4'd2;
    localparam logic [3:0] WIDTH_W = 4'd4;
    localparam logic [3:0] WIDTH_D = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RESP,
        DONE,
        DRAIN
    } mem_state_t;

    // Any size other than 1/2/4 is handled as a full doubleword.
    function automatic logic [3:0] norm_width(input logic [3:0] w);
        case (w)
            WIDTH_B, WIDTH_H, WIDTH_W: return w;
            default:                   return WIDTH_D;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Right-aligns the addressed bytes of a raw memory word, truncates to the
// access size and sign- or zero-extends the result.
module load_extract
    import mem_access_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [2:0]        offset,
    input  logic [3:0]        width,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;
    logic              fill;

    // Shift the addressed byte to lane 0, then extend from the access MSB.
    always_comb begin
        shifted = raw >> {offset, 3'b000};
        fill    = 1'b0;
        data    = shifted;
        case (width)
            WIDTH_B: begin
                fill = !is_unsigned && shifted[7];
                data = {{(DATA_W-8){fill}}, shifted[7:0]};
            end
            WIDTH_H: begin
                fill = !is_unsigned && shifted[15];
                data = {{(DATA_W-16){fill}}, shifted[15:0]};
            end
            WIDTH_W: begin
                fill = !is_unsigned && shifted[31];
                data = {{(DATA_W-32){fill}}, shifted[31:0]};
            end
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller: issues one valid/ready request per
// memory instruction, collects load data and holds the pipeline until done.
// Optional build macro MEM_MISALIGN_CHECK_EN: misaligned accesses are not
// issued and are reported on access_err instead.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              op_valid,
    input  logic              op_we,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [3:0]        op_width,
    input  logic              op_unsigned,
    input  logic [DATA_W-1:0] op_wdata,
    input  logic [7:0]        op_wmask,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic [DATA_W-1:0] load_data,
    output logic              stall,
    output logic              access_err
);

    mem_state_t        state_reg, state_next;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        width_reg;
    logic              uns_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [7:0]        wmask_reg;
    logic [DATA_W-1:0] load_data_reg;
    logic [DATA_W-1:0] extracted;
    logic [3:0]        eff_width;
    logic              accept;
    logic              resp_take;
    logic              misalign;

    assign eff_width = norm_width(op_width);

`ifdef MEM_MISALIGN_CHECK_EN
    // Crossing the 8-byte line or not naturally aligned to the access size.
    assign misalign = (({1'b0, op_addr[2:0]} + eff_width) > 4'd8) ||
                      ((op_addr[2:0] & (eff_width[2:0] - 3'd1)) != 3'd0);
`else
    assign misalign = 1'b0;
`endif

    load_extract #(.DATA_W(DATA_W)) u_extract (
        .raw         (mem_resp_rdata),
        .offset      (addr_reg[2:0]),
        .width       (width_reg),
        .is_unsigned (uns_reg),
        .data        (extracted)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic; a handshake coinciding with flush still commits.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        resp_take  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (op_valid && !flush) begin
                    accept     = 1'b1;
                    state_next = misalign ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    if (flush) state_next = we_reg ? IDLE : DRAIN;
                    else       state_next = we_reg ? DONE : WAIT_RESP;
                end else if (flush) begin
                    state_next = IDLE;
                end
            end
            WAIT_RESP: begin
                // A response landing with flush is consumed and dropped here,
                // otherwise DRAIN would wait for a response that never comes.
                if (mem_resp_valid) begin
                    resp_take  = !flush;
                    state_next = flush ? IDLE : DONE;
                end else if (flush) begin
                    state_next = DRAIN;
                end
            end
            DONE:    state_next = IDLE;
            DRAIN:   if (mem_resp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operation capture at acceptance and load result capture on response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            width_reg     <= WIDTH_D;
            uns_reg       <= 1'b0;
            wdata_reg     <= '0;
            wmask_reg     <= '0;
            load_data_reg <= '0;
        end else begin
            if (accept) begin
                we_reg    <= op_we;
                addr_reg  <= op_addr;
                width_reg <= eff_width;
                uns_reg   <= op_unsigned;
                wdata_reg <= op_wdata;
                wmask_reg <= op_wmask;
            end
            if (resp_take) load_data_reg <= extracted;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    logic err_reg;
    // Error flag lives exactly for the DONE cycle of a rejected access.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_reg <= 1'b0;
        else       err_reg <= accept && misalign;
    end
    assign access_err = err_reg;
`else
    assign access_err = 1'b0;
`endif

    assign mem_req_valid = (state_reg == REQ);
    assign mem_req_we    = we_reg;
    assign mem_req_addr  = {addr_reg[ADDR_W-1:3], 3'b000};
    assign mem_req_wdata = wdata_reg;
    assign mem_req_wmask = wmask_reg;
    assign load_data     = load_data_reg;
    assign stall         = op_valid && (state_reg != DONE) && (state_reg != DRAIN);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a queue of expected load results.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        op_valid, op_we, op_unsigned, flush;
    logic [63:0] op_addr, op_wdata;
    logic [3:0]  op_width;
    logic [7:0]  op_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata, load_data;
    logic        stall, access_err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_load;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rstn(rstn),
        .op_valid(op_valid), .op_we(op_we), .op_addr(op_addr),
        .op_width(op_width), .op_unsigned(op_unsigned),
        .op_wdata(op_wdata), .op_wmask(op_wmask), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .load_data(load_data), .stall(stall), .access_err(access_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access: ready held low for ready_delay cycles, load
    // response one cycle after the handshake, result checked at DONE.
    task automatic run_op(input string tag, input logic we, input logic [63:0] addr,
                          input logic [3:0] width, input logic uns,
                          input logic [63:0] wdata, input logic [7:0] wmask,
                          input logic [63:0] rdata, input int ready_delay,
                          input logic [63:0] exp_load);
        logic [63:0] exp;
        @(negedge clk);
        op_valid = 1'b1; op_we = we; op_addr = addr; op_width = width;
        op_unsigned = uns; op_wdata = wdata; op_wmask = wmask;
        if (!we) last_load = exp_load;
        exp_q.push_back(last_load);
        #1 chk({tag, " stall_c0"}, 64'(stall), 64'd1);
        @(negedge clk);
        chk({tag, " req_valid"}, 64'(mem_req_valid), 64'd1);
        for (int i = 0; i <= ready_delay; i++) begin
            chk({tag, " req_addr"}, mem_req_addr, {addr[63:3], 3'b000});
            chk({tag, " req_we"}, 64'(mem_req_we), 64'(we));
            chk({tag, " stall_req"}, 64'(stall), 64'd1);
            if (we) begin
                chk({tag, " req_wdata"}, mem_req_wdata, wdata);
                chk({tag, " req_wmask"}, 64'(mem_req_wmask), 64'(wmask));
            end
            mem_req_ready = (i == ready_delay);
            if (i != ready_delay) begin
                @(negedge clk);
                chk({tag, " req_held"}, 64'(mem_req_valid), 64'd1);
            end
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        if (!we) begin
            chk({tag, " stall_wait"}, 64'(stall), 64'd1);
            chk({tag, " req_dropped"}, 64'(mem_req_valid), 64'd0);
            mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
            @(negedge clk);
            mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        end
        chk({tag, " stall_done"}, 64'(stall), 64'd0);
        exp = exp_q.pop_front();
        chk({tag, " load_data"}, load_data, exp);
        chk({tag, " access_err"}, 64'(access_err), 64'd0);
        $display("txn %s we=%0d addr=%h load_data=%h", tag, we, addr, load_data);
        op_valid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; op_valid = 0; op_we = 0; op_addr = '0; op_width = 4'd8;
        op_unsigned = 0; op_wdata = '0; op_wmask = '0; flush = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
        last_load = '0;

        // Reset state.
        @(negedge clk);
        chk("rst req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst req_addr", mem_req_addr, 64'd0);
        chk("rst load_data", load_data, 64'd0);
        chk("rst stall_idle", 64'(stall), 64'd0);
        $display("txn reset");
        @(negedge clk);
        rstn = 1'b1;

        run_op("LD", 1'b0, 64'h1000_0008, 4'd8, 1'b0, '0, '0,
               64'h1122334455667788, 0, 64'h1122334455667788);
        run_op("LB_s", 1'b0, 64'h1000_0003, 4'd1, 1'b0, '0, '0,
               64'h0000_0000_80FF_0000, 0, 64'hFFFF_FFFF_FFFF_FF80);
        run_op("LB_u", 1'b0, 64'h1000_0003, 4'd1, 1'b1, '0, '0,
               64'h0000_0000_80FF_0000, 0, 64'h0000_0000_0000_0080);
        run_op("SH_bp", 1'b1, 64'h2000_0014, 4'd2, 1'b0, 64'h0000_BEEF_0000_0000,
               8'h30, '0, 3, '0);
        run_op("LH_s", 1'b0, 64'h1000_0006, 4'd2, 1'b0, '0, '0,
               64'h8001_0000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_8001);
        run_op("LW_u", 1'b0, 64'h1000_0004, 4'd4, 1'b1, '0, '0,
               64'hDEAD_BEEF_0000_0000, 1, 64'h0000_0000_DEAD_BEEF);
        run_op("L3_as_D", 1'b0, 64'h1000_0000, 4'd3, 1'b0, '0, '0,
               64'h8877_6655_4433_2211, 0, 64'h8877_6655_4433_2211);

        // Flush in WAIT_RESP: response discarded, load_data unchanged.
        @(negedge clk);
        op_valid = 1; op_we = 0; op_addr = 64'h3000_0000; op_width = 4'd8; op_unsigned = 0;
        @(negedge clk);
        chk("flw req_valid", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0; flush = 1; op_valid = 0;
        @(negedge clk);
        flush = 0; op_valid = 1;
        #1 chk("flw stall_drain", 64'(stall), 64'd0);
        op_valid = 0; mem_resp_valid = 1; mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        mem_resp_valid = 0; mem_resp_rdata = '0;
        chk("flw load_data", load_data, last_load);
        chk("flw req_valid_idle", 64'(mem_req_valid), 64'd0);
        $display("txn flush_wait_resp load_data=%h", load_data);
        run_op("LD_after_flush", 1'b0, 64'h3000_0008, 4'd8, 1'b0, '0, '0,
               64'h0102_0304_0506_0708, 0, 64'h0102_0304_0506_0708);

        // Flush in REQ before the handshake: request withdrawn.
        @(negedge clk);
        op_valid = 1; op_we = 1; op_addr = 64'h4000_0000; op_wdata = 64'h55; op_wmask = 8'h01;
        @(negedge clk);
        chk("flr req_valid", 64'(mem_req_valid), 64'd1);
        flush = 1; op_valid = 0;
        @(negedge clk);
        flush = 0;
        chk("flr req_dropped", 64'(mem_req_valid), 64'd0);
        $display("txn flush_req");

        // Reset during REQ: outputs return to reset values at once.
        @(negedge clk);
        op_valid = 1; op_we = 1; op_addr = 64'h5000_0010; op_wdata = 64'hFF; op_wmask = 8'hFF;
        @(negedge clk);
        chk("rsr req_valid", 64'(mem_req_valid), 64'd1);
        #2 rstn = 0;
        #1;
        chk("rsr req_valid_async", 64'(mem_req_valid), 64'd0);
        chk("rsr req_addr", mem_req_addr, 64'd0);
        chk("rsr req_we", 64'(mem_req_we), 64'd0);
        chk("rsr req_wdata", mem_req_wdata, 64'd0);
        chk("rsr req_wmask", 64'(mem_req_wmask), 64'd0);
        chk("rsr load_data", load_data, 64'd0);
        chk("rsr stall_idle", 64'(stall), 64'd1);
        op_valid = 0;
        last_load = '0;
        @(negedge clk);
        rstn = 1;
        $display("txn reset_mid_access");

`ifdef MEM_MISALIGN_CHECK_EN
        // Misaligned LW is rejected without a request.
        @(negedge clk);
        op_valid = 1; op_we = 0; op_addr = 64'h1000_0006; op_width = 4'd4; op_unsigned = 0;
        @(negedge clk);
        chk("mis req_valid", 64'(mem_req_valid), 64'd0);
        chk("mis access_err", 64'(access_err), 64'd1);
        chk("mis stall", 64'(stall), 64'd0);
        chk("mis load_data", load_data, last_load);
        op_valid = 0;
        @(negedge clk);
        chk("mis err_clear", 64'(access_err), 64'd0);
        $display("txn misaligned_rejected");
`else
        // Misaligned LW goes out as-is; bytes past the line are lost.
        run_op("LW_mis", 1'b0, 64'h1000_0006, 4'd4, 1'b0, '0, '0,
               64'hAABB_0000_0000_0000, 0, 64'h0000_0000_0000_AABB);
`endif

        run_op("LB_final", 1'b0, 64'h1000_0001, 4'd1, 1'b0, '0, '0,
               64'h0000_0000_0000_7F00, 0, 64'h0000_0000_0000_007F);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
